// File: rtl/mlaccel_pkg.sv
// Shared definitions for the ML accelerator memory arbiter.
//   req_id_e        : 2-bit requester tag carried with each memory access
//   MEM_RD_LATENCY  : cycles from the address cycle to valid mem_rdata
package mlaccel_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      HOST = 2'd1,
      SEQ  = 2'd2,
      COMP = 2'd3
   } req_id_e;

   localparam int MEM_RD_LATENCY = 2;

endpackage

// File: rtl/mlaccel_memarb_rsp_pipe.sv
// Tagged read-response latency pipe.
// A tag pushed in the grant cycle appears on pop_tag exactly MEM_RD_LATENCY
// cycles later. NONE marks an empty slot, so writes and idle cycles push NONE.
// Ports:
//   clock, reset : clock and synchronous active-high reset (clears all slots)
//   push_tag     : requester of the read granted this cycle, or NONE
//   pop_tag      : requester whose read data is on mem_rdata this cycle
module mlaccel_memarb_rsp_pipe
   import mlaccel_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  req_id_e push_tag,
   output req_id_e pop_tag
);

   req_id_e stage_q [MEM_RD_LATENCY];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MEM_RD_LATENCY; i++) begin
            stage_q[i] <= NONE;
         end
      end else begin
         stage_q[0] <= push_tag;
         for (int i = 1; i < MEM_RD_LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign pop_tag = stage_q[MEM_RD_LATENCY-1];

endmodule

// File: rtl/mlaccel_memarb.sv
// Three-way memory arbiter for the ML accelerator.
// Requesters: host command path (q_*, read/write with byte enables),
// sequencer fetch (s_*, read-only, 32-bit data), compute writeback
// (c_*, write-only, full word). One grant per cycle; host > compute >
// sequencer, except a sequencer stalled MAX_WAIT cycles wins outright.
//
// Handshake: x_ready is combinational from the valids and the wait counter.
// A request completes in the cycle x_valid && x_ready; no data is held in
// the arbiter. Reads return x_rvalid for one cycle exactly MEM_RD_LATENCY
// cycles after the grant, with x_rdata taken from mem_rdata that cycle;
// x_rdata is 0 whenever x_rvalid is low.
//
// Ports:
//   clock, reset                         clock, synchronous active-high reset
//   q_valid/q_ready/q_addr/q_wen/q_wdata host request (q_wen==0 is a read)
//   q_rvalid/q_rdata                     host read response (16 bit)
//   s_valid/s_ready/s_addr               sequencer read request
//   s_rvalid/s_rdata                     sequencer read response (32 bit)
//   c_valid/c_ready/c_addr/c_wdata       compute full-word write request
//   mem_addr/mem_wen/mem_wdata/mem_rdata memory port
module mlaccel_memarb
   import mlaccel_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        q_valid,
   output logic        q_ready,
   input  logic [15:0] q_addr,
   input  logic [1:0]  q_wen,
   input  logic [15:0] q_wdata,
   output logic        q_rvalid,
   output logic [15:0] q_rdata,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] s_addr,
   output logic        s_rvalid,
   output logic [31:0] s_rdata,
   input  logic        c_valid,
   output logic        c_ready,
   input  logic [15:0] c_addr,
   input  logic [15:0] c_wdata,
   output logic [15:0] mem_addr,
   output logic [1:0]  mem_wen,
   output logic [15:0] mem_wdata,
   input  logic [63:0] mem_rdata
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [3:0] wait_cnt;
   logic       seq_urgent;
   req_id_e    grant;
   req_id_e    push_tag;
   req_id_e    pop_tag;

   // Only the low 32 bits of the memory word are routed to any requester.
   logic unused_rdata_hi;
   assign unused_rdata_hi = ^mem_rdata[63:32];

   assign seq_urgent = s_valid && (wait_cnt == MAX_WAIT_C);

   // Grant selection. Forced to NONE during reset so every output is quiet
   // from the first reset cycle rather than one cycle later.
   always_comb begin
      grant = NONE;
      if (!reset) begin
         if (seq_urgent)   grant = SEQ;
         else if (q_valid) grant = HOST;
         else if (c_valid) grant = COMP;
         else if (s_valid) grant = SEQ;
      end
   end

   assign q_ready = (grant == HOST);
   assign s_ready = (grant == SEQ);
   assign c_ready = (grant == COMP);

   always_comb begin
      mem_addr  = '0;
      mem_wen   = '0;
      mem_wdata = '0;
      case (grant)
         HOST: begin
            mem_addr  = q_addr;
            mem_wen   = q_wen;
            mem_wdata = q_wdata;
         end
         COMP: begin
            mem_addr  = c_addr;
            mem_wen   = 2'b11;
            mem_wdata = c_wdata;
         end
         SEQ: begin
            mem_addr  = s_addr;
         end
         default: begin
         end
      endcase
   end

   // Sequencer starvation counter: counts stalled cycles, saturates at
   // MAX_WAIT, and drops to 0 as soon as the request is served or withdrawn.
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (!s_valid || s_ready) begin
         wait_cnt <= '0;
      end else if (wait_cnt != MAX_WAIT_C) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Only reads occupy a response slot.
   always_comb begin
      push_tag = NONE;
      if (grant == SEQ)                         push_tag = SEQ;
      else if (grant == HOST && q_wen == 2'b00) push_tag = HOST;
   end

   mlaccel_memarb_rsp_pipe u_rsp_pipe (
      .clock    (clock),
      .reset    (reset),
      .push_tag (push_tag),
      .pop_tag  (pop_tag)
   );

   // Gated by reset so a read in flight when reset rises never pulses.
   assign q_rvalid = !reset && (pop_tag == HOST);
   assign s_rvalid = !reset && (pop_tag == SEQ);
   assign q_rdata  = q_rvalid ? mem_rdata[15:0] : 16'h0000;
   assign s_rdata  = s_rvalid ? mem_rdata[31:0] : 32'h0000_0000;

endmodule

// File: tb/tb_mlaccel_memarb.sv
module tb_mlaccel_memarb;

   localparam int MAX_WAIT = 8;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic        q_valid = 0, q_ready, q_rvalid;
   logic [15:0] q_addr = 0, q_wdata = 0, q_rdata;
   logic [1:0]  q_wen = 0;
   logic        s_valid = 0, s_ready, s_rvalid;
   logic [15:0] s_addr = 0;
   logic [31:0] s_rdata;
   logic        c_valid = 0, c_ready;
   logic [15:0] c_addr = 0, c_wdata = 0;
   logic [15:0] mem_addr, mem_wdata;
   logic [1:0]  mem_wen;
   logic [63:0] mem_rdata;

   mlaccel_memarb #(.MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset(reset),
      .q_valid(q_valid), .q_ready(q_ready), .q_addr(q_addr), .q_wen(q_wen),
      .q_wdata(q_wdata), .q_rvalid(q_rvalid), .q_rdata(q_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata),
      .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_wdata(c_wdata),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // ---------------- memory responder (256 words, re-initialised on reset) ----------------
   function automatic logic [15:0] init_word(input int i);
      return 16'((i * 37) ^ 16'hC3C3);
   endfunction

   logic [15:0] env_mem [256];
   logic [63:0] rd_d1;

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
      end else begin
         if (mem_wen[0]) env_mem[mem_addr[7:0]][7:0]  <= mem_wdata[7:0];
         if (mem_wen[1]) env_mem[mem_addr[7:0]][15:8] <= mem_wdata[15:8];
      end
      rd_d1     <= {mem_addr, ~mem_addr, mem_addr ^ 16'h5A5A, env_mem[mem_addr[7:0]]};
      mem_rdata <= rd_d1;
   end

   // ---------------- reference model state ----------------
   typedef struct packed {
      logic [31:0] due;
      logic        is_host;
      logic [31:0] data;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [15:0] ref_mem [256];
   int          cyc;
   int          wcnt;
   int          n_checks = 0;
   int          n_fail = 0;

   logic        obs_q_ready, obs_s_ready, obs_c_ready, obs_q_rvalid, obs_s_rvalid;
   logic [15:0] obs_q_rdata, obs_mem_addr, obs_mem_wdata;
   logic [31:0] obs_s_rdata;
   logic [1:0]  obs_mem_wen;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic capture();
      obs_q_ready   = q_ready;
      obs_s_ready   = s_ready;
      obs_c_ready   = c_ready;
      obs_q_rvalid  = q_rvalid;
      obs_q_rdata   = q_rdata;
      obs_s_rvalid  = s_rvalid;
      obs_s_rdata   = s_rdata;
      obs_mem_addr  = mem_addr;
      obs_mem_wen   = mem_wen;
      obs_mem_wdata = mem_wdata;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int n);
      reset   = 1'b1;
      q_valid = 1'b1; q_addr = 16'h0011; q_wen = 2'b01; q_wdata = 16'hFFFF;
      s_valid = 1'b1; s_addr = 16'h0012;
      c_valid = 1'b1; c_addr = 16'h0013; c_wdata = 16'hFFFF;
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         capture();
         chk("rst_q_ready", obs_q_ready, 0);
         chk("rst_s_ready", obs_s_ready, 0);
         chk("rst_c_ready", obs_c_ready, 0);
         chk("rst_q_rvalid", obs_q_rvalid, 0);
         chk("rst_s_rvalid", obs_s_rvalid, 0);
         chk("rst_q_rdata", obs_q_rdata, 0);
         chk("rst_s_rdata", obs_s_rdata, 0);
         chk("rst_mem_addr", obs_mem_addr, 0);
         chk("rst_mem_wen", obs_mem_wen, 0);
         chk("rst_mem_wdata", obs_mem_wdata, 0);
         @(posedge clock); #1;
      end
      reset = 1'b0;
      q_valid = 0; s_valid = 0; c_valid = 0;
      exp_q.delete();
      wcnt = 0;
      cyc  = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
   endtask

   // One clock cycle: drive, predict from the rules, compare at negedge.
   task automatic step(input logic qv, input logic [15:0] qa, input logic [1:0] qw,
                       input logic [15:0] qd, input logic sv, input logic [15:0] sa,
                       input logic cv, input logic [15:0] ca, input logic [15:0] cd);
      int          who;   // 0 none, 1 host, 2 sequencer, 3 compute
      logic        e_qrv, e_srv;
      logic [15:0] e_qrd, e_addr, e_wdata;
      logic [31:0] e_srd;
      logic [1:0]  e_wen;
      rsp_t        r;
      q_valid = qv; q_addr = qa; q_wen = qw; q_wdata = qd;
      s_valid = sv; s_addr = sa;
      c_valid = cv; c_addr = ca; c_wdata = cd;
      @(negedge clock);
      capture();

      e_qrv = 0; e_qrd = 0; e_srv = 0; e_srd = 0;
      if (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
         r = exp_q.pop_front();
         if (r.is_host) begin e_qrv = 1; e_qrd = r.data[15:0]; end
         else           begin e_srv = 1; e_srd = r.data;       end
      end

      if (sv && wcnt == MAX_WAIT) who = 2;
      else if (qv)                who = 1;
      else if (cv)                who = 3;
      else if (sv)                who = 2;
      else                        who = 0;

      e_addr = 0; e_wen = 0; e_wdata = 0;
      if (who == 1) begin e_addr = qa; e_wen = qw; e_wdata = qd; end
      if (who == 3) begin e_addr = ca; e_wen = 2'b11; e_wdata = cd; end
      if (who == 2) e_addr = sa;

      chk($sformatf("c%0d_q_ready", cyc), obs_q_ready, who == 1);
      chk($sformatf("c%0d_s_ready", cyc), obs_s_ready, who == 2);
      chk($sformatf("c%0d_c_ready", cyc), obs_c_ready, who == 3);
      chk($sformatf("c%0d_mem_addr", cyc), obs_mem_addr, e_addr);
      chk($sformatf("c%0d_mem_wen", cyc), obs_mem_wen, e_wen);
      chk($sformatf("c%0d_mem_wdata", cyc), obs_mem_wdata, e_wdata);
      chk($sformatf("c%0d_q_rvalid", cyc), obs_q_rvalid, e_qrv);
      chk($sformatf("c%0d_q_rdata", cyc), obs_q_rdata, e_qrd);
      chk($sformatf("c%0d_s_rvalid", cyc), obs_s_rvalid, e_srv);
      chk($sformatf("c%0d_s_rdata", cyc), obs_s_rdata, e_srd);

      if (who == 1 && qw == 2'b00) begin
         r.due = 32'(cyc + 2); r.is_host = 1; r.data = {16'h0, ref_mem[qa[7:0]]};
         exp_q.push_back(r);
      end
      if (who == 2) begin
         r.due = 32'(cyc + 2); r.is_host = 0; r.data = {sa ^ 16'h5A5A, ref_mem[sa[7:0]]};
         exp_q.push_back(r);
      end
      if (who == 1 && qw[0]) ref_mem[qa[7:0]][7:0]  = qd[7:0];
      if (who == 1 && qw[1]) ref_mem[qa[7:0]][15:8] = qd[15:8];
      if (who == 3)          ref_mem[ca[7:0]] = cd;

      if (sv && who != 2) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : wcnt;
      else                wcnt = 0;
      cyc++;
      @(posedge clock); #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      @(posedge clock); #1;
      do_reset(3);

      // Host write then read-back of the same word.
      step(1, 16'h0010, 2'b11, 16'h1234, 0, 0, 0, 0, 0);
      step(1, 16'h0010, 2'b00, 16'h0000, 0, 0, 0, 0, 0);
      idle();
      chk("wr_no_rvalid", obs_q_rvalid, 0);
      idle();
      chk("rd_q_rvalid", obs_q_rvalid, 1);
      chk("rd_q_rdata", obs_q_rdata, 16'h1234);

      // All three valid from the first cycle after reset: starvation promotion.
      do_reset(1);
      for (int i = 0; i < 18; i++) begin
         step(1, 16'(i), 2'b00, 0, 1, 16'(32 + i), 1, 16'h0040, 16'h0);
         chk($sformatf("starve_s_ready_%0d", i), obs_s_ready, (i == 8 || i == 17));
         chk($sformatf("starve_q_ready_%0d", i), obs_q_ready, !(i == 8 || i == 17));
      end
      repeat (3) idle();

      // Four back-to-back sequencer reads.
      do_reset(1);
      for (int k = 0; k < 8; k++) begin
         if (k < 4) step(0, 0, 0, 0, 1, 16'(k), 0, 0, 0);
         else       idle();
         chk($sformatf("burst_s_rvalid_%0d", k), obs_s_rvalid, (k >= 2 && k <= 5));
         if (k >= 2 && k <= 5)
            chk($sformatf("burst_s_rdata_%0d", k), obs_s_rdata,
                {16'(k - 2) ^ 16'h5A5A, init_word(k - 2)});
      end

      // Host read and compute write in the same cycle.
      do_reset(1);
      step(1, 16'h0007, 2'b00, 0, 0, 0, 1, 16'h0007, 16'hBEEF);
      chk("hc_q_first", obs_q_ready, 1);
      chk("hc_c_wait", obs_c_ready, 0);
      step(0, 0, 0, 0, 0, 0, 1, 16'h0007, 16'hBEEF);
      chk("hc_c_ready", obs_c_ready, 1);
      chk("hc_c_wen", obs_mem_wen, 2'b11);
      chk("hc_c_wdata", obs_mem_wdata, 16'hBEEF);
      idle();
      chk("hc_q_rvalid", obs_q_rvalid, 1);
      step(1, 16'h0007, 2'b00, 0, 0, 0, 0, 0, 0);
      idle();
      idle();
      chk("hc_readback", obs_q_rdata, 16'hBEEF);

      // Host read and sequencer read together: host N, sequencer N+1.
      step(1, 16'h0003, 2'b00, 0, 1, 16'h0009, 0, 0, 0);
      step(0, 0, 0, 0, 1, 16'h0009, 0, 0, 0);
      idle();
      chk("hs_q_rvalid", obs_q_rvalid, 1);
      idle();
      chk("hs_s_rvalid", obs_s_rvalid, 1);

      // Reset while a sequencer read is in flight: it must be discarded.
      step(0, 0, 0, 0, 1, 16'h0003, 0, 0, 0);
      do_reset(1);
      for (int k = 0; k < 4; k++) begin
         idle();
         chk($sformatf("flush_s_rvalid_%0d", k), obs_s_rvalid, 0);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset(1);
         step($urandom_range(0, 99) < 45,
              16'($urandom_range(0, 31)),
              ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
              16'($urandom),
              $urandom_range(0, 99) < 70,
              16'($urandom_range(0, 31)),
              $urandom_range(0, 99) < 35,
              16'($urandom_range(0, 31)),
              16'($urandom));
      end
      repeat (3) idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mlaccel_memarb.md
MLACCEL_MEMARB -- requirements
Module: mlaccel_memarb

Interface
REQ-001 MAX_WAIT, default 8: consecutive stalled cycles after which a sequencer request is promoted to top priority (legal range 1..15).
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 q_valid  in  1  host (command path) request.
REQ-005 q_ready  out  1  host request granted this cycle.
REQ-006 q_addr  in  16  host word address.
REQ-007 q_wen  in  2  host byte write enables; 0 means read.
REQ-008 q_wdata  in  16  host write data.
REQ-009 q_rvalid  out  1  host read data valid.
REQ-010 q_rdata  out  16  host read data, mem_rdata[15:0].
REQ-011 s_valid  in  1  sequencer fetch request, read-only.
REQ-012 s_ready  out  1  sequencer request granted this cycle.
REQ-013 s_addr  in  16  sequencer word address.
REQ-014 s_rvalid  out  1  sequencer read data valid.
REQ-015 s_rdata  out  32  sequencer read data, mem_rdata[31:0].
REQ-016 c_valid  in  1  compute writeback request, write-only, full word.
REQ-017 c_ready  out  1  compute request granted this cycle.
REQ-018 c_addr  in  16  compute word address.
REQ-019 c_wdata  in  16  compute write data.
REQ-020 mem_addr  out  16  memory address.
REQ-021 mem_wen  out  2  memory byte write enables.
REQ-022 mem_wdata  out  16  memory write data.
REQ-023 mem_rdata  in  64  memory read data, valid 2 cycles after address cycle.

Function
REQ-024 Exactly one request SHALL be granted per cycle when any valid is high; grant (x_ready) is combinational from the valids and the wait counter, and a request completes in its grant cycle.
REQ-025 Default priority: host > compute > sequencer.
REQ-026 A 4-bit wait counter SHALL increment each cycle s_valid is high and s_ready low, clear on s_ready or !s_valid, and saturate at MAX_WAIT.
REQ-027 When the counter equals MAX_WAIT and s_valid is high, the sequencer SHALL win over host and compute that cycle.
REQ-028 Granted host: mem_addr=q_addr, mem_wen=q_wen, mem_wdata=q_wdata. Granted compute: mem_addr=c_addr, mem_wen=2'b11, mem_wdata=c_wdata. Granted sequencer: mem_addr=s_addr, mem_wen=0.
REQ-029 No grant: mem_addr=0, mem_wen=0, mem_wdata=0.
REQ-030 Reads (host with q_wen==0, all sequencer grants) SHALL enter a 2-stage response pipe tagged with the requester; the matching rvalid pulses exactly 2 cycles after grant, for one cycle, with rdata sampled from mem_rdata that cycle.
REQ-031 Writes SHALL produce no rvalid pulse.
REQ-032 Back-to-back reads, one per cycle, SHALL be supported with 2 in flight; responses return in grant order.
REQ-033 Simultaneous host read and sequencer read: host granted cycle N, sequencer N+1, q_rvalid at N+2, s_rvalid at N+3.
REQ-034 q_rdata/s_rdata SHALL be 0 when the corresponding rvalid is low.

Reset
REQ-035 While reset is high: all x_ready=0, all rvalid=0, mem_wen=0, mem_addr=0, mem_wdata=0, wait counter=0, pipe cleared; reads in flight at reset SHALL be discarded and never pulse rvalid.
REQ-036 The first grant SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-037 Package mlaccel_pkg SHALL hold the 2-bit requester ID (NONE, HOST, SEQ, COMP) and MEM_RD_LATENCY=2.
REQ-038 Sub-module mlaccel_memarb_rsp_pipe SHALL implement the tagged latency pipe; arbitration stays in mlaccel_memarb.

Verification
REQ-039 Host write 0x1234 to 0x0010, then host read 0x0010 -> q_rvalid 2 cycles after read grant, q_rdata=0x1234, no rvalid for the write.
REQ-040 q_valid, c_valid, s_valid held high from cycle 0 with MAX_WAIT=8 -> host granted cycles 0-7, s_ready in cycle 8, counter back to 0 in cycle 9.
REQ-041 Sequencer reads at 0x0000..0x0003 on consecutive cycles -> four s_rvalid pulses on consecutive cycles, in address order, s_rdata=mem_rdata[31:0].
REQ-042 Compute write 0xBEEF and host read both valid in cycle N -> host read granted N, compute write N+1, mem_wen=2'b11, q_rvalid at N+2.
REQ-043 Sequencer read granted, reset asserted next cycle for 1 cycle -> no s_rvalid ever; all outputs 0 during reset.
